sram_capture_ctrl: RTL and testbench

SRAM_CAPTURE_CTRL -- requirements
Module: sram_capture_ctrl

---
 rtl/capture_pkg.sv | 17 +
 rtl/sram_capture_ctrl.sv | 124 ++++++++++++
 tb/tb_sram_capture_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/capture_pkg.sv
// Shared definitions for the SRAM capture controller: state encoding and default widths.
package capture_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    FILL    = 3'd2,
    DONE    = 3'd3,
    RD_ADDR = 3'd4,
    RD_WAIT = 3'd5,
    RD_HOLD = 3'd6
  } state_t;

endpackage

// File: rtl/sram_capture_ctrl.sv
// Captures a full buffer of samples into an external SRAM, then streams it out with valid/ready.
// Define CAPTURE_TRIG_EN to hold capture in ARMED until trig is seen after arm.
module sram_capture_ctrl
  import capture_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic              trig,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              rd_req,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_din,
  output logic              sram_wen,
  input  logic [DATA_W-1:0] sram_dout
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

`ifdef CAPTURE_TRIG_EN
  localparam state_t START_ST = ARMED;
`else
  localparam state_t START_ST = FILL;
  logic unused_trig;
  assign unused_trig = trig;
`endif

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] wptr, rptr;
  logic              idle_like;

  assign idle_like = (state == IDLE) || (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      wptr   <= '0;
      rptr   <= '0;
      m_data <= '0;
    end else begin
      state <= state_nxt;
      if (idle_like && arm) begin
        wptr <= '0;
      end else if (state == FILL && s_valid) begin
        wptr <= wptr + 1'b1;
      end
      if (idle_like && !arm && rd_req) begin
        rptr <= '0;
      end else if (state == RD_HOLD && m_ready) begin
        rptr <= rptr + 1'b1;
      end
      // SRAM read data is valid the cycle after the address was presented
      if (state == RD_WAIT) begin
        m_data <= sram_dout;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    sram_wen  = 1'b0;
    sram_addr = '0;
    sram_din  = '0;
    m_valid   = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE, DONE: begin
        busy = 1'b0;
        done = (state == DONE);
        if (arm) begin
          state_nxt = START_ST;
        end else if (rd_req) begin
          state_nxt = RD_ADDR;
        end
      end
      ARMED: begin
`ifdef CAPTURE_TRIG_EN
        if (trig) begin
          state_nxt = FILL;
        end
`else
        state_nxt = IDLE;
`endif
      end
      FILL: begin
        if (s_valid) begin
          sram_wen  = 1'b1;
          sram_addr = wptr;
          sram_din  = s_data;
          if (wptr == LAST_ADDR) begin
            state_nxt = DONE;
          end
        end
      end
      RD_ADDR: begin
        sram_addr = rptr;
        state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        sram_addr = rptr;
        state_nxt = RD_HOLD;
      end
      RD_HOLD: begin
        sram_addr = rptr;
        m_valid   = 1'b1;
        if (m_ready) begin
          state_nxt = (rptr == LAST_ADDR) ? DONE : RD_ADDR;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sram_capture_ctrl.sv
// Scoreboard bench for sram_capture_ctrl with a 16-word buffer and a behavioural SRAM.
module tb_sram_capture_ctrl;
  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 0, rst_n = 0, arm = 0, trig = 0, s_valid = 0, rd_req = 0, m_ready = 0;
  logic [DW-1:0] s_data = '0;
  logic [DW-1:0] m_data, sram_din, sram_dout;
  logic          m_valid, busy, done, sram_wen;
  logic [AW-1:0] sram_addr;

  sram_capture_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .trig(trig), .s_data(s_data), .s_valid(s_valid),
    .rd_req(rd_req), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .busy(busy),
    .done(done), .sram_addr(sram_addr), .sram_din(sram_din), .sram_wen(sram_wen),
    .sram_dout(sram_dout)
  );

  always #5 clk = ~clk;

  // Synchronous SRAM: registered read port
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (sram_wen) mem[sram_addr] <= sram_din;
    sram_dout <= mem[sram_addr];
  end

  int errors = 0, checks = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  wr_t           wq[$];
  logic [DW-1:0] rq[$];
  int            hs_cyc[$];
  logic [DW-1:0] ref_buf [DEPTH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops expectations whenever the DUT writes or hands over a word
  wr_t           mon_e;
  logic          pv = 0, pr = 0;
  logic [DW-1:0] pd = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (sram_wen === 1'b1) begin
        if (wq.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          mon_e = wq.pop_front();
          chk("wr_addr", sram_addr, mon_e.a);
          chk("wr_data", sram_din, mon_e.d);
        end
      end
      if (pv && !pr) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, pd);
      end
      if (m_valid === 1'b1 && m_ready) begin
        if (rq.size() == 0) chk("unexpected_word", 1, 0);
        else begin
          chk("rd_data", m_data, rq.pop_front());
          hs_cyc.push_back(cyc);
        end
      end else if (m_valid === 1'b1 && rq.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end
    end
    pv = (m_valid === 1'b1) && rst_n;
    pr = m_ready;
    pd = m_data;
  end

  task automatic capture(input int rst_at, input bit gaps, input bit with_rd, input bit seq);
    int w = 0;
    arm = 1; rd_req = with_rd; s_valid = 1'($urandom); s_data = 8'($urandom);
    tick();
    arm = 0; rd_req = 0;
`ifdef CAPTURE_TRIG_EN
    for (int i = 0; i < 10; i++) begin
      s_valid = 1'($urandom); s_data = 8'($urandom); trig = (i == 9);
      tick();
    end
    trig = 0;
`endif
    while (w < DEPTH) begin
      if (w == rst_at) begin
        rst_n = 0; s_valid = 0; arm = 0; rd_req = 0;
        tick();
        rst_n = 1;
        chk("rst_wen", sram_wen, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", sram_addr, 0);
        chk("rst_mvalid", m_valid, 0);
        return;
      end
      s_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_data  = seq ? DW'(8'h10 + w) : DW'($urandom);
      arm     = ($urandom_range(0, 7) == 0);
      rd_req  = ($urandom_range(0, 7) == 0);
      if (s_valid) begin
        wq.push_back('{a: w[AW-1:0], d: s_data});
        ref_buf[w] = s_data;
        w++;
      end
      tick();
    end
    s_valid = 0; arm = 0; rd_req = 0;
    chk("done_after_fill", done, 1);
    chk("busy_after_fill", busy, 0);
    chk("wq_drained", wq.size(), 0);
  endtask

  // mode 0: ready high, 1: stall five cycles on word 3, 2: random ready
  task automatic readout(input int mode);
    int c0, held = 0, guard = 0;
    hs_cyc.delete();
    for (int i = 0; i < DEPTH; i++) rq.push_back(ref_buf[i]);
    rd_req = 1; m_ready = 1; c0 = cyc;
    tick();
    rd_req = 0;
    while (hs_cyc.size() < DEPTH && guard < 2000) begin
      case (mode)
        1: if (m_valid && hs_cyc.size() == 3 && held < 5) begin
             m_ready = 0; held++;
           end else m_ready = 1;
        2: m_ready = 1'($urandom_range(0, 1));
        default: m_ready = 1;
      endcase
      tick();
      guard++;
    end
    if (guard >= 2000) chk("readout_timeout", 0, 1);
    m_ready = 0;
    chk("done_after_read", done, 1);
    chk("rq_drained", rq.size(), 0);
    if (mode == 0 && hs_cyc.size() == DEPTH) begin
      chk("first_latency", hs_cyc[0] - c0, 3);
      for (int i = 1; i < DEPTH; i++) chk("word_interval", hs_cyc[i] - hs_cyc[i-1], 3);
    end
    if (mode == 1) chk("stall_cycles", held, 5);
  endtask

  initial begin
    rst_n = 0;
    tick(); tick();
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_mvalid", m_valid, 0);
    chk("reset_mdata", m_data, 0);
    chk("reset_wen", sram_wen, 0);
    chk("reset_addr", sram_addr, 0);
    chk("reset_din", sram_din, 0);
    rst_n = 1;
    tick();
    capture(-1, 0, 0, 1);
    readout(0);
    readout(1);
    capture(7, 1, 0, 0);
    capture(-1, 1, 0, 0);
    readout(2);
    capture(-1, 0, 1, 0);
    readout(2);
    capture(-1, 1, 0, 0);
    readout(0);
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
